test_mode_sequencer: RTL and testbench

- Generates the `test_mode` and `tdsp_clk_enable` selects consumed by the chip's test clock mux.
- Sequences functional↔scan switchover safely: freezes functional logic, stops the TDSP clock, guards the mux select change, and acknowledges to the tester.
- Also owns the functional TDSP clock-enable policy: request-driven, with idle-timeout shutoff.
- Sits in the always-on clock domain, beside the test clock mux.

---
 rtl/test_mode_sequencer.sv | 175 +++++++++++++++++
 tb/tb_test_mode_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/test_mode_sequencer.sv
// test_mode_sequencer
// Drives the test clock mux selects from the always-on domain. Moves the chip
// between functional and scan clocking in safe order: freeze functional state,
// stop the TDSP clock, switch the mux inside guard windows, then acknowledge
// the tester. In functional mode it also runs the TDSP clock-enable policy:
// enable on request, shut off after IDLE_CYCLES consecutive idle cycles.
//
// Ports:
//   clk             in   functional / always-on clock
//   rst             in   synchronous reset, active-high
//   test_req        in   tester scan request (asynchronous pin)
//   tdsp_req        in   functional request for the TDSP clock
//   tdsp_idle       in   TDSP has no pending work
//   func_hold       out  freeze functional state machines
//   test_mode       out  mux select, 1 = scan_clk on all clocks
//   tdsp_clk_enable out  TDSP clock gate enable
//   test_ack        out  scan mode established
//   busy            out  sequencer is not in FUNC
module test_mode_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int IDLE_CYCLES  = 8,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic test_req,
  input  logic tdsp_req,
  input  logic tdsp_idle,
  output logic func_hold,
  output logic test_mode,
  output logic tdsp_clk_enable,
  output logic test_ack,
  output logic busy
);

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;

  typedef enum logic [2:0] {
    FUNC    = 3'd0,
    HOLD    = 3'd1,
    SWITCH  = 3'd2,
    TEST    = 3'd3,
    EXIT    = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       idle_cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   test_req_s;

  assign test_req_s = sync[SYNC_STAGES-1];

  // Synchronizer chain for the asynchronous tester request pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], test_req};
    end
  end

  // Sequencer FSM with registered outputs and TDSP enable policy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= FUNC;
      cnt             <= CNT_ZERO;
      idle_cnt        <= CNT_ZERO;
      func_hold       <= 1'b0;
      test_mode       <= 1'b0;
      tdsp_clk_enable <= 1'b0;
      test_ack        <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        FUNC: begin
          func_hold <= 1'b0;
          test_mode <= 1'b0;
          test_ack  <= 1'b0;
          cnt       <= CNT_ZERO;
          if (test_req_s) begin
            // Scan entry wins over a simultaneous TDSP request.
            state           <= HOLD;
            func_hold       <= 1'b1;
            busy            <= 1'b1;
            tdsp_clk_enable <= 1'b0;
            idle_cnt        <= CNT_ZERO;
          end else begin
            busy <= 1'b0;
            if (tdsp_req) begin
              tdsp_clk_enable <= 1'b1;
              idle_cnt        <= CNT_ZERO;
            end else if (tdsp_clk_enable && tdsp_idle) begin
              if (idle_cnt == IDLE_LAST) begin
                tdsp_clk_enable <= 1'b0;
                idle_cnt        <= CNT_ZERO;
              end else begin
                idle_cnt <= idle_cnt + CNT_ONE;
              end
            end else begin
              idle_cnt <= CNT_ZERO;
            end
          end
        end
        HOLD: begin
          if (!test_req_s) begin
            // Abort before the mux select ever moved.
            state <= RELEASE;
            cnt   <= CNT_ZERO;
          end else if ((cnt == HOLD_LAST) && tdsp_idle) begin
            state     <= SWITCH;
            cnt       <= CNT_ZERO;
            test_mode <= 1'b1;
          end else if (cnt != HOLD_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            cnt <= cnt;
          end
        end
        SWITCH: begin
          // Request drops are deliberately ignored until TEST.
          if (cnt == GUARD_LAST) begin
            state    <= TEST;
            cnt      <= CNT_ZERO;
            test_ack <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        TEST: begin
          if (!test_req_s) begin
            state     <= EXIT;
            cnt       <= CNT_ZERO;
            test_ack  <= 1'b0;
            test_mode <= 1'b0;
          end else begin
            cnt <= CNT_ZERO;
          end
        end
        EXIT: begin
          if (cnt == GUARD_LAST) begin
            state <= RELEASE;
            cnt   <= CNT_ZERO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        RELEASE: begin
          state     <= FUNC;
          cnt       <= CNT_ZERO;
          func_hold <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state           <= FUNC;
          cnt             <= CNT_ZERO;
          idle_cnt        <= CNT_ZERO;
          func_hold       <= 1'b0;
          test_mode       <= 1'b0;
          tdsp_clk_enable <= 1'b0;
          test_ack        <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_mode_sequencer.sv
// Directed self-checking bench for test_mode_sequencer (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_test_mode_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic test_req;
  logic tdsp_req;
  logic tdsp_idle;
  logic func_hold;
  logic test_mode;
  logic tdsp_clk_enable;
  logic test_ack;
  logic busy;

  int checks   = 0;
  int failures = 0;

  test_mode_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .test_req        (test_req),
    .tdsp_req        (tdsp_req),
    .tdsp_idle       (tdsp_idle),
    .func_hold       (func_hold),
    .test_mode       (test_mode),
    .tdsp_clk_enable (tdsp_clk_enable),
    .test_ack        (test_ack),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  initial begin
    rst       = 1'b1;
    test_req  = 1'b0;
    tdsp_req  = 1'b0;
    tdsp_idle = 1'b1;
    tick();
    tick();
    chk("rst_func_hold", func_hold, 1'b0);
    chk("rst_test_mode", test_mode, 1'b0);
    chk("rst_enable", tdsp_clk_enable, 1'b0);
    chk("rst_ack", test_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Scan entry and exit, tdsp_idle = 1. This point is edge 0.
    test_req = 1'b1;
    tick(); tick();
    chk("entry_hold_e2", func_hold, 1'b0);
    chk("entry_busy_e2", busy, 1'b0);
    tick();
    chk("entry_hold_e3", func_hold, 1'b1);
    chk("entry_busy_e3", busy, 1'b1);
    chk("entry_mode_e3", test_mode, 1'b0);
    tick(); tick(); tick();
    chk("entry_mode_e6", test_mode, 1'b0);
    tick();
    chk("entry_mode_e7", test_mode, 1'b1);
    chk("entry_ack_e7", test_ack, 1'b0);
    chk("entry_en_e7", tdsp_clk_enable, 1'b0);
    tick();
    chk("entry_ack_e8", test_ack, 1'b0);
    tick();
    chk("entry_ack_e9", test_ack, 1'b1);
    tick(); tick();
    chk("entry_ack_hold", test_ack, 1'b1);

    test_req = 1'b0;
    tick(); tick();
    chk("exit_mode_d2", test_mode, 1'b1);
    chk("exit_ack_d2", test_ack, 1'b1);
    tick();
    chk("exit_mode_d3", test_mode, 1'b0);
    chk("exit_ack_d3", test_ack, 1'b0);
    chk("exit_hold_d3", func_hold, 1'b1);
    tick(); tick();
    chk("exit_hold_d5", func_hold, 1'b1);
    chk("exit_mode_d5", test_mode, 1'b0);
    tick();
    chk("exit_hold_d6", func_hold, 1'b0);
    chk("exit_busy_d6", busy, 1'b0);

    // Reset in the middle of TEST.
    test_req = 1'b1;
    repeat (10) tick();
    chk("rstmid_ack_before", test_ack, 1'b1);
    rst      = 1'b1;
    test_req = 1'b0;
    tick();
    rst = 1'b0;
    chk("rstmid_mode", test_mode, 1'b0);
    chk("rstmid_hold", func_hold, 1'b0);
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_ack", test_ack, 1'b0);
    repeat (5) tick();
    chk("rstmid_busy_later", busy, 1'b0);

    // HOLD stall while the TDSP is busy.
    tdsp_idle = 1'b0;
    test_req  = 1'b1;
    tick(); tick(); tick();
    chk("stall_hold", func_hold, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_mode", test_mode, 1'b0);
    end
    tdsp_idle = 1'b1;
    tick();
    chk("stall_release_mode", test_mode, 1'b1);
    test_req = 1'b0;
    repeat (12) tick();
    chk("stall_busy_end", busy, 1'b0);
    chk("stall_mode_end", test_mode, 1'b0);

    // Abort: request sampled high on edges 1..4 only.
    test_req = 1'b1;
    tick(); tick(); tick();
    chk("abort_hold_e3", func_hold, 1'b1);
    tick();
    test_req = 1'b0;
    chk("abort_mode_e4", test_mode, 1'b0);
    tick(); tick(); tick();
    chk("abort_mode_e7", test_mode, 1'b0);
    chk("abort_hold_e7", func_hold, 1'b1);
    tick();
    chk("abort_hold_e8", func_hold, 1'b0);
    chk("abort_busy_e8", busy, 1'b0);
    chk("abort_mode_e8", test_mode, 1'b0);
    chk("abort_ack_e8", test_ack, 1'b0);

    // TDSP idle timeout: request sampled on edges 1..3.
    tdsp_req = 1'b1;
    tick();
    chk("idle_en_e1", tdsp_clk_enable, 1'b1);
    tick(); tick();
    tdsp_req = 1'b0;
    for (int e = 4; e <= 10; e++) begin
      tick();
      chk("idle_en_on", tdsp_clk_enable, 1'b1);
    end
    tick();
    chk("idle_en_e11", tdsp_clk_enable, 1'b0);

    // Same, but tdsp_idle low for the edge-5 sample restarts the count.
    tick();
    tdsp_req = 1'b1;
    tick();
    chk("restart_en_e1", tdsp_clk_enable, 1'b1);
    tick(); tick();
    tdsp_req = 1'b0;
    tick();
    tdsp_idle = 1'b0;
    tick();
    tdsp_idle = 1'b1;
    for (int e = 6; e <= 12; e++) begin
      tick();
      chk("restart_en_on", tdsp_clk_enable, 1'b1);
    end
    tick();
    chk("restart_en_e13", tdsp_clk_enable, 1'b0);

    // Collision: enable already on when the scan request arrives.
    tdsp_req = 1'b1;
    tick();
    chk("coll_en_pre", tdsp_clk_enable, 1'b1);
    test_req = 1'b1;
    tick(); tick();
    chk("coll_en_e2", tdsp_clk_enable, 1'b1);
    chk("coll_hold_e2", func_hold, 1'b0);
    tick();
    chk("coll_en_e3", tdsp_clk_enable, 1'b0);
    chk("coll_hold_e3", func_hold, 1'b1);
    for (int e = 4; e <= 12; e++) begin
      tick();
      chk("coll_en_off", tdsp_clk_enable, 1'b0);
    end
    chk("coll_ack", test_ack, 1'b1);
    tdsp_req = 1'b0;
    test_req = 1'b0;
    repeat (10) tick();
    chk("coll_busy_end", busy, 1'b0);
    chk("coll_en_end", tdsp_clk_enable, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
